// File: rtl/alu_op_sequencer.sv
// Initiator for the ALU operand/function interface: issues one op, waits ALU_LATENCY, returns the result.
// Optional build macro ALU_SEQ_CHAIN_EN feeds the previous result low byte back as operand A.
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned MAX_OP      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_chain,
  output logic [3:0]  alu_fsel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_hi,
  input  logic [7:0]  alu_lo,
  input  logic [3:0]  alu_sreg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_sreg,
  output logic [3:0]  rsp_op,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned OpW   = 4;
  localparam int unsigned DataW = 8;
  localparam int unsigned ResW  = 16;

  localparam logic [CntW-1:0] LatLoad  = CntW'(ALU_LATENCY);
  localparam logic [OpW-1:0]  MaxOpVal = OpW'(MAX_OP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               cmd_ready_q;
  logic [OpW-1:0]     alu_fsel_q;
  logic [DataW-1:0]   alu_a_q;
  logic [DataW-1:0]   alu_b_q;
  logic               rsp_valid_q;
  logic [ResW-1:0]    rsp_result_q;
  logic [3:0]         rsp_sreg_q;
  logic [OpW-1:0]     rsp_op_q;
  logic               rsp_err_q;
  logic [ResW-1:0]    op_count_q;
  logic [DataW-1:0]   a_sel_d;
  logic               accept;
  logic               op_illegal;

`ifdef ALU_SEQ_CHAIN_EN
  logic [DataW-1:0]   last_res_q;
`else
  logic               unused_chain;
  assign unused_chain = cmd_chain;
`endif

  assign accept     = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
  assign op_illegal = cmd_op > MaxOpVal;

  // Operand A source: command field, or the previous result when chaining
  always_comb begin
    a_sel_d = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
    if (cmd_chain) a_sel_d = last_res_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      alu_fsel_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_sreg_q   <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      last_res_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (op_illegal) begin
              // Rejected op: answer immediately, ALU outputs untouched
              state_q      <= ST_DONE;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_sreg_q   <= '0;
              rsp_op_q     <= cmd_op;
            end else begin
              state_q    <= ST_WAIT;
              alu_fsel_q <= cmd_op;
              alu_a_q    <= a_sel_d;
              alu_b_q    <= cmd_b;
              cnt_q      <= LatLoad;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_DONE;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= {alu_hi, alu_lo};
            rsp_sreg_q   <= alu_sreg;
            rsp_op_q     <= alu_fsel_q;
            rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            last_res_q   <= alu_lo;
`endif
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_valid_q && rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_count_q  <= op_count_q + ResW'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_fsel   = alu_fsel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_sreg   = rsp_sreg_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at ALU_LATENCY=1, one at ALU_LATENCY=3.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_SEQ_CHAIN_EN
  localparam logic [7:0] ChainA = 8'h55;
`else
  localparam logic [7:0] ChainA = 8'd13;
`endif

  // Latency-1 instance
  logic        cmd_valid, cmd_ready, cmd_chain, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  cmd_op, alu_fsel, alu_sreg, rsp_sreg, rsp_op;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b, alu_hi, alu_lo;
  logic [15:0] rsp_result, op_count;

  // Latency-3 instance
  logic        cmd3_valid, cmd3_ready, cmd3_chain, rsp3_valid, rsp3_ready, rsp3_err;
  logic [3:0]  cmd3_op, alu3_fsel, alu3_sreg, rsp3_sreg, rsp3_op;
  logic [7:0]  cmd3_a, cmd3_b, alu3_a, alu3_b, alu3_hi, alu3_lo;
  logic [15:0] rsp3_result, op3_count;

  alu_op_sequencer #(.ALU_LATENCY(1), .MAX_OP(8)) u_lat1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_fsel(alu_fsel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_sreg(alu_sreg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_sreg(rsp_sreg), .rsp_op(rsp_op), .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_op_sequencer #(.ALU_LATENCY(3), .MAX_OP(8)) u_lat3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_op(cmd3_op),
    .cmd_a(cmd3_a), .cmd_b(cmd3_b), .cmd_chain(cmd3_chain),
    .alu_fsel(alu3_fsel), .alu_a(alu3_a), .alu_b(alu3_b),
    .alu_hi(alu3_hi), .alu_lo(alu3_lo), .alu_sreg(alu3_sreg),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_result(rsp3_result),
    .rsp_sreg(rsp3_sreg), .rsp_op(rsp3_op), .rsp_err(rsp3_err), .op_count(op3_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0; rsp_ready = 1'b0;
    alu_hi = 8'h12; alu_lo = 8'h34; alu_sreg = 4'b1010;
    cmd3_valid = 1'b0; cmd3_op = '0; cmd3_a = '0; cmd3_b = '0; cmd3_chain = 1'b0; rsp3_ready = 1'b0;
    alu3_hi = 8'h7F; alu3_lo = 8'h02; alu3_sreg = 4'b0011;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 16'(cmd_ready), 16'd1);

    // Basic op at latency 1
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'd6; cmd_b = 8'd9;
    tick();
    cmd_valid = 1'b0;
    chk("basic_fsel", 16'(alu_fsel), 16'd1);
    chk("basic_a", 16'(alu_a), 16'd6);
    chk("basic_b", 16'(alu_b), 16'd9);
    chk("basic_busy", 16'(cmd_ready), 16'd0);
    tick();
    chk("basic_no_rsp_e1", 16'(rsp_valid), 16'd0);
    tick();
    chk("basic_rsp_valid", 16'(rsp_valid), 16'd1);
    chk("basic_result", rsp_result, 16'h1234);
    chk("basic_sreg", 16'(rsp_sreg), 16'b1010);
    chk("basic_op", 16'(rsp_op), 16'd1);
    chk("basic_err", 16'(rsp_err), 16'd0);
    chk("basic_cnt_pre", op_count, 16'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("basic_rsp_drop", 16'(rsp_valid), 16'd0);
    chk("basic_cnt", op_count, 16'd1);
    chk("basic_ready_back", 16'(cmd_ready), 16'd1);

    // Backpressure with a pending command behind the response
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 8'h11; cmd_b = 8'h22;
    alu_hi = 8'hAB; alu_lo = 8'hCD; alu_sreg = 4'b0101;
    tick();
    cmd_op = 4'd4; cmd_a = 8'd1; cmd_b = 8'd2;
    tick();
    tick();
    chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
    chk("bp_result", rsp_result, 16'hABCD);
    for (int i = 0; i < 5; i++) begin
      alu_hi = 8'(i); alu_lo = 8'(i + 16); alu_sreg = 4'(i);
      tick();
      chk("bp_hold_valid", 16'(rsp_valid), 16'd1);
      chk("bp_hold_result", rsp_result, 16'hABCD);
      chk("bp_hold_sreg", 16'(rsp_sreg), 16'b0101);
      chk("bp_hold_op", 16'(rsp_op), 16'd2);
      chk("bp_hold_busy", 16'(cmd_ready), 16'd0);
      chk("bp_hold_fsel", 16'(alu_fsel), 16'd2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_valid", 16'(rsp_valid), 16'd0);
    chk("bp_hs_cnt", op_count, 16'd2);
    chk("bp_hs_not_accepted", 16'(alu_fsel), 16'd2);
    chk("bp_hs_ready", 16'(cmd_ready), 16'd1);
    alu_hi = 8'h00; alu_lo = 8'h55; alu_sreg = 4'b0000;
    tick();
    cmd_valid = 1'b0;
    chk("bp_accept_fsel", 16'(alu_fsel), 16'd4);
    chk("bp_accept_a", 16'(alu_a), 16'd1);
    chk("bp_accept_b", 16'(alu_b), 16'd2);
    tick();
    tick();
    chk("seed_result", rsp_result, 16'h0055);
    chk("seed_op", 16'(rsp_op), 16'd4);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("seed_cnt", op_count, 16'd3);

    // Illegal opcode: immediate errored response
    cmd_valid = 1'b1; cmd_op = 4'd12; cmd_a = 8'd3; cmd_b = 8'd6;
    alu_hi = 8'hEE; alu_lo = 8'hEE; alu_sreg = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("ill_rsp_valid", 16'(rsp_valid), 16'd1);
    chk("ill_err", 16'(rsp_err), 16'd1);
    chk("ill_result", rsp_result, 16'h0000);
    chk("ill_sreg", 16'(rsp_sreg), 16'd0);
    chk("ill_op", 16'(rsp_op), 16'd12);
    chk("ill_fsel_kept", 16'(alu_fsel), 16'd4);
    chk("ill_a_kept", 16'(alu_a), 16'd1);
    chk("ill_b_kept", 16'(alu_b), 16'd2);
    rsp_ready = 1'b1;
    tick();
    chk("ill_cnt", op_count, 16'd4);

    // Chain: operand A from the last legal result low byte
    cmd_valid = 1'b1; cmd_op = 4'd6; cmd_chain = 1'b1; cmd_a = 8'd13; cmd_b = 8'd85;
    tick();
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    chk("chain_a", 16'(alu_a), 16'(ChainA));
    chk("chain_b", 16'(alu_b), 16'd85);
    chk("chain_fsel", 16'(alu_fsel), 16'd6);
    tick();
    tick();
    chk("chain_rsp_op", 16'(rsp_op), 16'd6);
    chk("chain_rsp_err", 16'(rsp_err), 16'd0);
    tick();
    rsp_ready = 1'b0;
    chk("chain_cnt", op_count, 16'd5);

    // Reset one cycle after acceptance drops the op
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'd7; cmd_b = 8'd8;
    tick();
    cmd_valid = 1'b0;
    chk("mid_accept_a", 16'(alu_a), 16'd7);
    reset = 1'b1;
    #1;
    chk("mid_rst_a", 16'(alu_a), 16'd0);
    chk("mid_rst_fsel", 16'(alu_fsel), 16'd0);
    chk("mid_rst_ready", 16'(cmd_ready), 16'd0);
    chk("mid_rst_cnt", op_count, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 16'(cmd_ready), 16'd1);
    chk("post_rst_cnt", op_count, 16'd0);
    tick();
    tick();
    chk("post_rst_no_rsp", 16'(rsp_valid), 16'd0);

    // Latency 3: capture at E0+4, operands stable throughout
    cmd3_valid = 1'b1; cmd3_op = 4'd3; cmd3_a = 8'd127; cmd3_b = 8'd125;
    tick();
    cmd3_valid = 1'b0; cmd3_a = 8'd0; cmd3_b = 8'd0;
    for (int i = 0; i < 4; i++) begin
      chk("lat3_a_stable", 16'(alu3_a), 16'd127);
      chk("lat3_b_stable", 16'(alu3_b), 16'd125);
      chk("lat3_no_rsp", 16'(rsp3_valid), 16'd0);
      tick();
    end
    chk("lat3_rsp_valid", 16'(rsp3_valid), 16'd1);
    chk("lat3_result", rsp3_result, 16'h7F02);
    chk("lat3_op", 16'(rsp3_op), 16'd3);
    chk("lat3_a_final", 16'(alu3_a), 16'd127);
    rsp3_ready = 1'b1;
    tick();
    chk("lat3_cnt", op3_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
